mram_sync_bank: RTL and testbench

- Parametrised synchronous main-memory bank for the CPU datapath, replacing the asynchronous latch-written RAM.
- Port A: read/write, byte-write enables, ready/valid handshake, registered read data.
- Port B: read-only, for instruction fetch.
- Built-in clear engine zeroes the whole array on request, one word per cycle.

---
 rtl/mram_sync_bank_if.sv | 38 +++
 rtl/mram_sync_bank.sv | 168 ++++++++++++++++
 tb/tb_mram_sync_bank.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mram_sync_bank_if.sv
// Bus interface for the synchronous main-memory bank.
// Groups the port A read/write handshake and the port B fetch read port.
interface mram_sync_bank_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) ();
    localparam int BE_WIDTH = DATA_WIDTH / 8;

    // Port A: read/write with ready/valid handshake
    logic                  a_req;
    logic                  a_ready;
    logic                  a_we;
    logic [BE_WIDTH-1:0]   a_be;
    logic [ADDR_WIDTH-1:0] a_address;
    logic [DATA_WIDTH-1:0] a_data_in;
    logic [DATA_WIDTH-1:0] a_data_out;
    logic                  a_rvalid;

    // Port B: read-only instruction fetch
    logic                  b_req;
    logic [ADDR_WIDTH-1:0] b_address;
    logic [DATA_WIDTH-1:0] b_data_out;
    logic                  b_rvalid;

    modport master (
        output a_req, a_we, a_be, a_address, a_data_in,
        input  a_ready, a_data_out, a_rvalid,
        output b_req, b_address,
        input  b_data_out, b_rvalid
    );

    modport slave (
        input  a_req, a_we, a_be, a_address, a_data_in,
        output a_ready, a_data_out, a_rvalid,
        input  b_req, b_address,
        output b_data_out, b_rvalid
    );
endinterface

// File: rtl/mram_sync_bank.sv
// Synchronous main-memory bank.
// Port A: read/write with byte enables, registered read data (latency 1).
// Port B: read-only fetch port, never stalled.
// Clear engine: zeroes the array one word per cycle; port A is held off
// while it runs. Same-cycle write/read of one address is read-first.
module mram_sync_bank #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    mram_sync_bank_if.slave        bus,
    input  logic                   clr_start,
    output logic                   clr_busy,
    output logic                   clr_done
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Last counter value of a clear; the counter has one spare bit so the
    // top address is written before the terminal compare can alias to zero.
    localparam logic [ADDR_WIDTH:0] CNT_LAST = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } clr_state_t;

    // Merge new_word into old_word on the lanes selected by be.
    function automatic logic [DATA_WIDTH-1:0] byte_merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [BE_WIDTH-1:0]   be
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < BE_WIDTH; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [DEPTH];

    clr_state_t            state_r;
    clr_state_t            state_nxt_s;
    logic [ADDR_WIDTH:0]   cnt_r;
    logic [ADDR_WIDTH:0]   cnt_nxt_s;
    logic                  clr_we_s;
    logic                  clr_busy_r;
    logic                  clr_done_r;

    logic                  a_ready_s;
    logic                  a_accept_s;
    logic                  a_wr_s;
    logic                  a_rd_s;

    logic [DATA_WIDTH-1:0] a_data_out_r;
    logic                  a_rvalid_r;
    logic [DATA_WIDTH-1:0] b_data_out_r;
    logic                  b_rvalid_r;

    // Port A is only held off while the clear engine is sweeping the array.
    assign a_ready_s  = ~clr_busy_r;
    assign a_accept_s = bus.a_req & a_ready_s;
    assign a_wr_s     = a_accept_s & bus.a_we;
    assign a_rd_s     = a_accept_s & ~bus.a_we;

    assign bus.a_ready    = a_ready_s;
    assign bus.a_data_out = a_data_out_r;
    assign bus.a_rvalid   = a_rvalid_r;
    assign bus.b_data_out = b_data_out_r;
    assign bus.b_rvalid   = b_rvalid_r;
    assign clr_busy       = clr_busy_r;
    assign clr_done       = clr_done_r;

    // Clear FSM next-state, counter and array-clear strobe.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        clr_we_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (clr_start) begin
                    state_nxt_s = ST_CLEAR;
                    cnt_nxt_s   = '0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                clr_we_s  = 1'b1;
                cnt_nxt_s = cnt_r + CNT_ONE;
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Clear FSM state, counter and status flags (flags track the next state).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            clr_busy_r <= 1'b0;
            clr_done_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            clr_busy_r <= (state_nxt_s == ST_CLEAR);
            clr_done_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Array write port: clear sweep or port A byte-masked write (never both,
    // since port A is not ready during a sweep). Contents survive reset.
    always_ff @(posedge clk) begin
        if (clr_we_s) begin
            mem_r[cnt_r[ADDR_WIDTH-1:0]] <= '0;
        end else if (a_wr_s) begin
            mem_r[bus.a_address] <= byte_merge(mem_r[bus.a_address],
                                               bus.a_data_in, bus.a_be);
        end
    end

    // Port A read register: captures old word (read-first), holds until next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_data_out_r <= '0;
            a_rvalid_r   <= 1'b0;
        end else begin
            a_rvalid_r <= a_rd_s;
            if (a_rd_s) begin
                a_data_out_r <= mem_r[bus.a_address];
            end
        end
    end

    // Port B read register: serviced every cycle, including during a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_data_out_r <= '0;
            b_rvalid_r   <= 1'b0;
        end else begin
            b_rvalid_r <= bus.b_req;
            if (bus.b_req) begin
                b_data_out_r <= mem_r[bus.b_address];
            end
        end
    end
endmodule

// File: tb/tb_mram_sync_bank.sv
// Self-checking bench for mram_sync_bank (16-word instance).
// A reference array predicts read data; expected words are queued when a
// read is issued and compared when the matching rvalid pulse appears.
module tb_mram_sync_bank;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic clr_start = 1'b0;
    logic clr_busy;
    logic clr_done;

    mram_sync_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mram_sync_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done)
    );

    always #5 clk = ~clk;

    logic [31:0] model [DEPTH];
    logic [31:0] exp_a [$];
    logic [31:0] exp_b [$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old_w & ~mask) | (new_w & mask);
    endfunction

    // One cycle of stimulus; called at posedge+1, returns at next posedge+1.
    task automatic cycle_op(input logic do_a, input logic we, input logic [3:0] be,
                            input logic [3:0] aa, input logic [31:0] ad,
                            input logic do_b, input logic [3:0] ba);
        bus.a_req     = do_a;
        bus.a_we      = we;
        bus.a_be      = be;
        bus.a_address = aa;
        bus.a_data_in = ad;
        bus.b_req     = do_b;
        bus.b_address = ba;
        if (do_a && !we) exp_a.push_back(model[aa]);
        if (do_b) exp_b.push_back(model[ba]);
        @(posedge clk);
        if (do_a && we) model[aa] = merge_word(model[aa], ad, be);
        #1;
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle_op(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    endtask

    task automatic fill(input logic [31:0] val);
        for (int i = 0; i < DEPTH; i++) cycle_op(1'b1, 1'b1, 4'hF, 4'(i), val, 1'b0, 4'h0);
    endtask

    task automatic read_all();
        for (int i = 0; i < DEPTH; i++) cycle_op(1'b1, 1'b0, 4'h0, 4'(i), 32'h0, 1'b1, 4'(15 - i));
        idle(2);
    endtask

    // Scoreboard: compare every rvalid pulse against the queued expectation.
    always @(negedge clk) begin
        if (bus.a_rvalid) begin
            check_val("a_rvalid_pending", 32'(exp_a.size() > 0), 32'd1);
            if (exp_a.size() > 0) check_val("a_data_out", bus.a_data_out, exp_a.pop_front());
        end
        if (bus.b_rvalid) begin
            check_val("b_rvalid_pending", 32'(exp_b.size() > 0), 32'd1);
            if (exp_b.size() > 0) check_val("b_data_out", bus.b_data_out, exp_b.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [31:0] rd;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_be = 4'h0; bus.a_address = 4'h0;
        bus.a_data_in = 32'h0; bus.b_req = 1'b0; bus.b_address = 4'h0;

        // Reset values
        #12;
        check_val("rst_a_data_out", bus.a_data_out, 32'h0);
        check_val("rst_a_rvalid", 32'(bus.a_rvalid), 32'd0);
        check_val("rst_b_data_out", bus.b_data_out, 32'h0);
        check_val("rst_b_rvalid", 32'(bus.b_rvalid), 32'd0);
        check_val("rst_clr_busy", 32'(clr_busy), 32'd0);
        check_val("rst_clr_done", 32'(clr_done), 32'd0);
        check_val("rst_a_ready", 32'(bus.a_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Initial sweep so the array is known-zero
        clr_start = 1'b1;
        @(posedge clk); #1;
        clr_start = 1'b0;
        for (int i = 0; i < 17; i++) begin @(posedge clk); end
        #1;

        // Full-word write then read
        cycle_op(1'b1, 1'b1, 4'hF, 4'h1, 32'hDEADBEEF, 1'b0, 4'h0);
        cycle_op(1'b1, 1'b0, 4'h0, 4'h1, 32'h0, 1'b0, 4'h0);
        // Byte-enable merge: expected 0x11BB33DD
        cycle_op(1'b1, 1'b1, 4'hF, 4'h2, 32'h11223344, 1'b0, 4'h0);
        cycle_op(1'b1, 1'b1, 4'h5, 4'h2, 32'hAABBCCDD, 1'b0, 4'h0);
        cycle_op(1'b1, 1'b1, 4'h0, 4'h2, 32'hFFFFFFFF, 1'b0, 4'h0);
        cycle_op(1'b1, 1'b0, 4'h0, 4'h2, 32'h0, 1'b0, 4'h0);
        idle(2);
        check_val("be_merge_model", model[2], 32'h11BB33DD);
        // A write / B read same address: read-first, then new value
        cycle_op(1'b1, 1'b1, 4'hF, 4'h3, 32'h00000005, 1'b1, 4'h3);
        cycle_op(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h3);
        idle(2);

        // Random mixed traffic on both ports
        for (int i = 0; i < 40; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rd = $urandom;
            cycle_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     ra, rd, 1'($urandom_range(0, 1)), rb);
        end
        idle(2);

        // Clear with timing checks, same-cycle A read, held A request, B during sweep
        fill(32'hFFFFFFFF);
        clr_start     = 1'b1;
        bus.a_req     = 1'b1; bus.a_we = 1'b0; bus.a_address = 4'h5;
        exp_a.push_back(32'hFFFFFFFF);
        @(posedge clk); #1;
        clr_start     = 1'b0;
        bus.a_address = 4'h3;
        for (int c = 1; c <= 16; c++) begin
            if (c == 1) begin bus.b_req = 1'b1; bus.b_address = 4'h0; exp_b.push_back(32'hFFFFFFFF); end
            if (c == 2) begin bus.b_req = 1'b1; bus.b_address = 4'hF; exp_b.push_back(32'hFFFFFFFF); end
            if (c == 3) begin bus.b_req = 1'b1; bus.b_address = 4'h0; exp_b.push_back(32'h0); end
            @(negedge clk);
            check_val("clr_a_ready", 32'(bus.a_ready), 32'd0);
            check_val("clr_busy", 32'(clr_busy), 32'd1);
            check_val("clr_done_early", 32'(clr_done), 32'd0);
            @(posedge clk); #1;
            bus.b_req = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        exp_a.push_back(32'h0);
        @(negedge clk);
        check_val("clr_done_pulse", 32'(clr_done), 32'd1);
        check_val("clr_done_a_ready", 32'(bus.a_ready), 32'd1);
        check_val("clr_done_busy", 32'(clr_busy), 32'd0);
        @(posedge clk); #1;
        bus.a_req = 1'b0;
        @(negedge clk);
        check_val("clr_done_after", 32'(clr_done), 32'd0);
        @(posedge clk); #1;
        read_all();

        // Reset aborts a clear after five words
        fill(32'hA5A5A5A5);
        clr_start = 1'b1;
        @(posedge clk); #1;
        clr_start = 1'b0;
        for (int i = 0; i < 5; i++) begin @(posedge clk); end
        #1;
        rst_n = 1'b0;
        #1;
        check_val("abort_busy", 32'(clr_busy), 32'd0);
        check_val("abort_done", 32'(clr_done), 32'd0);
        for (int i = 0; i < 5; i++) model[i] = 32'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_val("abort_done_quiet", 32'(clr_done), 32'd0);
        end
        @(posedge clk); #1;
        read_all();

        // Reset while a read result is being presented
        cycle_op(1'b1, 1'b1, 4'hF, 4'h9, 32'h13579BDF, 1'b0, 4'h0);
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_address = 4'h9;
        @(posedge clk); #1;
        bus.a_req = 1'b0;
        check_val("midread_rvalid", 32'(bus.a_rvalid), 32'd1);
        check_val("midread_data", bus.a_data_out, 32'h13579BDF);
        rst_n = 1'b0;
        #1;
        check_val("midread_rst_rvalid", 32'(bus.a_rvalid), 32'd0);
        check_val("midread_rst_data", bus.a_data_out, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        check_val("a_queue_drained", 32'(exp_a.size()), 32'd0);
        check_val("b_queue_drained", 32'(exp_b.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
